// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard and forwarding controller for the RV32I pipeline, placed between
//   the instruction decoder and the execute stage. It records the destination
//   of every in-flight instruction across NUM_STAGES post-decode stages
//   (EXE=0, MEM=1, WB=2, ...). From that record it produces:
//     - a forwarding select per source operand, and
//     - a load-use stall for loads whose data is not yet forwardable.
//
//   Optional feature (compile-time macro HAZ_PERF_CNT_EN):
//     Adds saturating 32-bit stall_cnt / flush_cnt performance counters and a
//     synchronous perf_clr input. When the macro is undefined, those ports and
//     counters are absent and everything else behaves identically.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rstB,
  input  logic                  clkEn,
  input  logic                  flush,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_we,
  input  logic                  dec_is_load,
`ifdef HAZ_PERF_CNT_EN
  input  logic                  perf_clr,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
`endif
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic                  busy
);

  // One tracked in-flight instruction.
  typedef struct packed {
    logic                  v;   // slot holds a real instruction
    logic [REG_ADDR_W-1:0] rd;  // destination register
    logic                  we;  // instruction writes rd
    logic                  ld;  // instruction is a memory load
  } entry_t;

  // Result of searching the table for one source operand.
  typedef struct packed {
    logic [SEL_W-1:0] sel;      // 0 = register file, k+1 = stage k
    logic             load_use; // youngest producer is a not-yet-ready load
  } lookup_t;

  // Index 0 is the youngest stage (EXE); higher indices are older.
  entry_t [NUM_STAGES-1:0] entries;

  lookup_t lkp_rs1;
  lookup_t lkp_rs2;
  logic    hazard;
  entry_t  new_entry;

  // Search every stage for the youngest producer of src. The loop runs from
  // the oldest stage to the youngest, so the last hit written is the
  // youngest one. That also means a not-ready load in an older stage is
  // overridden by any younger producer of the same register. Register x0 is
  // never a hazard because its value is constant.
  function automatic lookup_t lookup(input logic                    used,
                                     input logic [REG_ADDR_W-1:0]   src,
                                     input entry_t [NUM_STAGES-1:0] tbl);
    lookup_t r;
    r = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (used && tbl[k].v && tbl[k].we && (tbl[k].rd == src) && (src != '0)) begin
        r.sel      = SEL_W'(k + 1);
        r.load_use = tbl[k].ld && (k < LOAD_LAT);
      end
    end
    return r;
  endfunction

  // Per-source forwarding lookup and the combined load-use stall.
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    lkp_rs1 = lookup(dec_rs1_used, dec_rs1, entries);
    lkp_rs2 = lookup(dec_rs2_used, dec_rs2, entries);
    hazard  = lkp_rs1.load_use | lkp_rs2.load_use;
    // A taken branch kills the decode slot, so the stall is dropped. While
    // the pipe is frozen there is nothing to hold back either.
    stall       = clkEn & dec_valid & ~flush & hazard;
    // The selects are still driven during a stall; the consumer ignores them.
    fwd_sel_rs1 = lkp_rs1.sel;
    fwd_sel_rs2 = lkp_rs2.sel;
  end

  // Entry entering stage 0: a bubble whenever decode is flushed or stalled.
  always_comb begin
    new_entry.v  = dec_valid & ~flush & ~stall;
    new_entry.rd = dec_rd;
    new_entry.we = dec_we;
    new_entry.ld = dec_is_load;
  end

  // Busy while any stage still tracks a real instruction.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      busy = busy | entries[k].v;
    end
  end

  // Advance the tracking table one stage toward WB on each enabled clock.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      // NOTE: the table is a small flop array, not a RAM, so it is reset; clearing every valid bit drops all in-flight tracking at once.
      entries <= '0;
    end else if (clkEn) begin
      // NOTE: non-blocking assignments make each stage take its neighbour's old value, so the shift order does not matter.
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0] <= new_entry;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating count of cycles in which decode is stalled.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Saturating count of enabled cycles in which a flush is taken.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      flush_cnt <= '0;
    end else if (perf_clr) begin
      flush_cnt <= '0;
    end else if (clkEn && flush && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. One instance uses the default
//   parameters (3 stages, 1-cycle load). A second instance with 4 stages and
//   LOAD_LAT=2 shares the same stimulus and is checked in its own section.
//   Build with +define+HAZ_PERF_CNT_EN to also exercise the perf counters.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rstB;
  logic       clkEn;
  logic       flush;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic [4:0] dec_rd;
  logic       dec_we;
  logic       dec_is_load;

  logic       stall;
  logic [1:0] fwd_sel_rs1;
  logic [1:0] fwd_sel_rs2;
  logic       busy;

  logic       stall4;
  logic [2:0] fwd4_rs1;
  logic [2:0] fwd4_rs2;
  logic       busy4;

`ifdef HAZ_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt4;
  logic [31:0] flush_cnt4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rstB         (rstB),
    .clkEn        (clkEn),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd       (dec_rd),
    .dec_we       (dec_we),
    .dec_is_load  (dec_is_load),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr     (perf_clr),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .stall        (stall),
    .fwd_sel_rs1  (fwd_sel_rs1),
    .fwd_sel_rs2  (fwd_sel_rs2),
    .busy         (busy)
  );

  hazard_scoreboard #(.NUM_STAGES(4), .LOAD_LAT(2)) dut4 (
    .clk          (clk),
    .rstB         (rstB),
    .clkEn        (clkEn),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd       (dec_rd),
    .dec_we       (dec_we),
    .dec_is_load  (dec_is_load),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr     (perf_clr),
    .stall_cnt    (stall_cnt4),
    .flush_cnt    (flush_cnt4),
`endif
    .stall        (stall4),
    .fwd_sel_rs1  (fwd4_rs1),
    .fwd_sel_rs2  (fwd4_rs2),
    .busy         (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the decode slot, then let the combinational outputs settle.
  task automatic apply(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    dec_valid    = v;
    dec_rs1      = rs1;
    dec_rs1_used = u1;
    dec_rs2      = rs2;
    dec_rs2_used = u2;
    dec_rd       = rd;
    dec_we       = we;
    dec_is_load  = ld;
    flush        = fl;
    #1;
  endtask

  task automatic nop();
    apply(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstB  = 1'b0;
    clkEn = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    nop();
    tick();
    check("reset_stall", stall, 0);
    check("reset_fwd1", fwd_sel_rs1, 0);
    check("reset_fwd2", fwd_sel_rs2, 0);
    check("reset_busy", busy, 0);
`ifdef HAZ_PERF_CNT_EN
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);
`endif
    rstB = 1'b1;

    // ALU forwarding: add x5, then readers at distance 1 and 3.
    apply(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    check("alu_first_fwd1", fwd_sel_rs1, 0);
    check("alu_first_stall", stall, 0);
    tick();
    apply(1, 5'd5, 1, 5'd6, 1, 5'd6, 1, 0, 0);
    check("alu_d1_stall", stall, 0);
    check("alu_d1_fwd1", fwd_sel_rs1, 1);
    check("alu_d1_fwd2", fwd_sel_rs2, 0);
    check("alu_d1_busy", busy, 1);
    tick();
    nop();
    check("nop_unused_fwd1", fwd_sel_rs1, 0);
    tick();
    apply(1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0);
    check("alu_d3_fwd1", fwd_sel_rs1, 3);
    check("alu_d3_fwd2", fwd_sel_rs2, 2);
    check("alu_d3_stall", stall, 0);
    tick();

    // Two writers of x5 in a row: the younger one wins.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    apply(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    tick();
    apply(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    check("youngest_wins_fwd1", fwd_sel_rs1, 1);
    tick();

    // Load-use on rs2: one stall cycle, then forward from MEM.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
    tick();
    apply(1, 5'd0, 0, 5'd7, 1, 5'd8, 1, 0, 0);
    check("lu_stall_on", stall, 1);
    check("lu_stall_fwd2", fwd_sel_rs2, 1);
    tick();
    check("lu_stall_off", stall, 0);
    check("lu_fwd2_mem", fwd_sel_rs2, 2);
    tick();

    // Two loads feeding both sources.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0);
    tick();
    apply(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 0);
    tick();
    apply(1, 5'd10, 1, 5'd11, 1, 5'd0, 0, 0, 0);
    check("dual_stall_on", stall, 1);
    check("dual_fwd1", fwd_sel_rs1, 2);
    check("dual_fwd2", fwd_sel_rs2, 1);
    tick();
    check("dual_stall_off", stall, 0);
    check("dual_fwd1_after", fwd_sel_rs1, 3);
    check("dual_fwd2_after", fwd_sel_rs2, 2);
    tick();

    // Drain the pipe.
    nop();
    tick();
    tick();
    tick();
    check("drain_busy", busy, 0);

    // Flush wins over a load-use hazard and inserts a bubble.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0);
    tick();
    apply(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 1);
    check("flush_stall", stall, 0);
    check("flush_fwd1", fwd_sel_rs1, 1);
    tick();
    apply(0, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    check("flush_bubble_fwd1", fwd_sel_rs1, 2);
    check("flush_busy_load", busy, 1);
    tick();
    check("flush_busy_wb", busy, 1);
    tick();
    check("flush_busy_gone", busy, 0);

    // A load writing x0 is stored but never hazards.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    tick();
    apply(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
    check("x0_stall", stall, 0);
    check("x0_fwd1", fwd_sel_rs1, 0);
    check("x0_fwd2", fwd_sel_rs2, 0);
    check("x0_busy", busy, 1);
    tick();

    // Freeze with a load in EXE: table holds, stall forced low.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0);
    tick();
    clkEn = 1'b0;
    apply(1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("freeze_stall", stall, 0);
      check("freeze_fwd1", fwd_sel_rs1, 1);
      tick();
    end
    clkEn = 1'b1;
    #1;
    check("unfreeze_stall", stall, 1);
    check("unfreeze_fwd1", fwd_sel_rs1, 1);
    tick();
    check("unfreeze_stall_off", stall, 0);
    check("unfreeze_fwd1_mem", fwd_sel_rs1, 2);

    // Asynchronous reset mid-cycle clears everything before the next edge.
    check("pre_rst_busy", busy, 1);
    rstB = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_stall", stall, 0);
    check("midrst_fwd1", fwd_sel_rs1, 0);
    check("midrst_busy4", busy4, 0);
    rstB = 1'b1;
    #1;

    // LOAD_LAT=2 with 4 stages: two stall cycles, then forward from stage 2.
    nop();
    tick();
    apply(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
    tick();
    apply(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    check("ll2_stall_c1", stall4, 1);
    check("ll2_fwd_c1", fwd4_rs1, 1);
    tick();
    check("ll2_stall_c2", stall4, 1);
    check("ll2_fwd_c2", fwd4_rs1, 2);
    tick();
    check("ll2_stall_off", stall4, 0);
    check("ll2_fwd_final", fwd4_rs1, 3);
    check("ll2_busy", busy4, 1);
    tick();

`ifdef HAZ_PERF_CNT_EN
    // Counters: clear, then 2 flush cycles and 3 single-cycle load-use stalls.
    nop();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr_stall", stall_cnt, 0);
    check("perf_clr_flush", flush_cnt, 0);
    apply(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 0);
      tick();
      apply(1, 5'd13, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      nop();
      tick();
    end
    check("perf_stall_cnt", stall_cnt, 3);
    check("perf_flush_cnt", flush_cnt, 2);
    // Clear has priority over a simultaneous flush increment.
    apply(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    nop();
    check("perf_clr2_stall", stall_cnt, 0);
    check("perf_clr2_flush", flush_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the RV32I pipeline. It sits between the instruction decoder and the execute stage.
- Tracks the destination registers of every in-flight instruction across a configurable number of post-decode stages.
- Outputs a per-source forwarding select and a load-use stall. Load latency is configurable, which generalises the fixed three-stage / single-cycle-load scheme.

Parameters:
- NUM_STAGES, 3, number of tracked post-decode stages (EXE=0, MEM=1, WB=2, ...); range 1..8.
- REG_ADDR_W, 5, register index width.
- LOAD_LAT, 1, stages a load needs before its data is forwardable; a load in stage k < LOAD_LAT is not yet forwardable; range 1..NUM_STAGES-1.
- SEL_W, $clog2(NUM_STAGES+1), forwarding select width (derived).

Ports:
- clk  in  1  core clock.
- rstB  in  1  asynchronous active-low reset.
- clkEn  in  1  pipeline advance enable; low freezes all state.
- flush  in  1  jump/branch taken; instruction in decode is killed.
- dec_valid  in  1  decode slot holds a real instruction (0 for NOP/bubble).
- dec_rs1  in  REG_ADDR_W  source 1 index.
- dec_rs2  in  REG_ADDR_W  source 2 index.
- dec_rs1_used  in  1  instruction reads rs1.
- dec_rs2_used  in  1  instruction reads rs2.
- dec_rd  in  REG_ADDR_W  destination index.
- dec_we  in  1  instruction writes rd.
- dec_is_load  in  1  instruction is a memory load.
- stall  out  1  hold decode/fetch this cycle.
- fwd_sel_rs1  out  SEL_W  0 = register file; k+1 = forward from stage k.
- fwd_sel_rs2  out  SEL_W  same for rs2.
- busy  out  1  any tracked stage valid.

Behaviour:
- State: per stage k an entry {v, rd, we, ld}.
- Reset (rstB low, asynchronous): all entries cleared. stall=0, fwd_sel_rs1/2=0, busy=0. Reset mid-operation discards all in-flight tracking immediately.
- Match rule, per source: match_k = src_used & v[k] & we[k] & (rd[k]==src) & (src!=0).
  - Priority goes to the youngest stage (lowest k).
  - fwd_sel = k+1 of the youngest match, else 0. fwd_sel is combinational from registered entries and the dec_* inputs.
- Load-use hazard: youngest match with ld[k]=1 and k < LOAD_LAT.
  - Older non-youngest matches are ignored, because the youngest producer wins.
- stall = clkEn & dec_valid & !flush & (load-use hazard on rs1 or rs2).
  - When stall=1, fwd_sel outputs still reflect the matching stage; the consumer ignores them.
- Update on posedge clk when clkEn=1:
  - Entries k>0 take entry k-1 (shift toward WB); the oldest entry is discarded.
  - Entry 0 takes {dec_valid & !flush & !stall, dec_rd, dec_we, dec_is_load}. When flush or stall is asserted, a bubble (v=0) is inserted.
- clkEn=0: no shift, entries hold. stall is forced 0. fwd_sel is still driven.
- Latency:
  - A load in EXE with LOAD_LAT=L stalls a dependent consumer for exactly L cycles.
  - The consumer then forwards from stage L (fwd_sel=L+1).
- Simultaneous flush and hazard: flush wins, stall=0, bubble inserted.
- Destination x0 is never tracked as a hazard (the src!=0 check); entries with rd=0 may still be stored.
- Both sources hazarding on different loads: stall holds until both producers are forwardable.
- busy = OR of all v.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds 32-bit outputs stall_cnt and flush_cnt:
  - Each increments by 1 on posedge clk when clkEn & stall or clkEn & flush respectively.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0 asynchronously.
- Adds input perf_clr, a synchronous clear that takes priority over increment.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults; cycle N issue add x5 (we=1). Cycle N+1 issue sub reading rs1=x5 -> stall=0, fwd_sel_rs1=1. Cycle N+2 an unrelated NOP, then a reader of x5 in cycle N+3 -> fwd_sel=3.
- Defaults; lw x7 in cycle N, reader of rs2=x7 in cycle N+1 -> stall=1 for exactly 1 cycle, then fwd_sel_rs2=2, stall=0.
- LOAD_LAT=2, NUM_STAGES=4; lw x9 followed immediately by a reader of x9 -> stall=1 for 2 consecutive cycles, then fwd_sel_rs1=3.
- lw x3 then a dependent instruction with flush=1 in the same cycle -> stall=0, a bubble enters stage 0, busy reflects only the load; x0 source after a write to x0 -> fwd_sel=0.
- clkEn=0 for 4 cycles with a load in EXE -> entries frozen, stall=0. Assert rstB=0 mid-sequence -> busy, stall and fwd_sel all 0 before the next clock edge.
- HAZ_PERF_CNT_EN defined: 3 stall cycles and 2 flush cycles -> stall_cnt=3, flush_cnt=2; perf_clr=1 -> both 0 next cycle.
